mul_seq_radix4: RTL

// - Iterative radix-4 unsigned/signed multiplier built from A_W/2 mul_2x2 cells; one 2-bit B digit per cycle.
// - Replaces a full array multiplier in area-constrained PE variants; sits between operand fetch and PE accumulator.
// - Valid/ready on both sides; shift-adds 2x2 partial products into a registered accumulator.

---
 rtl/mul_seq_radix4_if.sv | 26 ++
 rtl/mul_seq_radix4.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/mul_seq_radix4_if.sv
// rtl/mul_seq_radix4_if.sv - operand/product handshake bundle for mul_seq_radix4
// master drives operands and product acceptance; slave is the multiplier.

interface mul_seq_radix4_if #(
  parameter int A_W = 8,
  parameter int B_W = 8
);
  logic                 i_valid;
  logic                 o_ready;
  logic [A_W-1:0]       i_a;
  logic [B_W-1:0]       i_b;
  logic                 o_valid;
  logic                 i_ready;
  logic [A_W+B_W-1:0]   o_ab;
  logic                 o_busy;

  modport master (
    output i_valid, i_a, i_b, i_ready,
    input  o_ready, o_valid, o_ab, o_busy
  );

  modport slave (
    input  i_valid, i_a, i_b, i_ready,
    output o_ready, o_valid, o_ab, o_busy
  );
endinterface

// File: rtl/mul_seq_radix4.sv
// rtl/mul_seq_radix4.sv - iterative radix-4 multiplier, one 2-bit B digit per cycle
// Optional macro MUL_SEQ_SIGNED_EN: two's complement operands via magnitude/sign.

module mul_2x2 #(
  parameter int APPROX = 0
) (
  input  logic [1:0] a_i,
  input  logic [1:0] b_i,
  output logic [3:0] p_o
);
  // UDM cell: only 3*3 deviates, giving 7 so the result fits in 3 bits
  always_comb begin
    p_o = {2'b00, a_i} * {2'b00, b_i};
    if ((APPROX != 0) && (&a_i) && (&b_i)) begin
      p_o = 4'd7;
    end
  end
endmodule

module mul_seq_radix4 #(
  parameter int A_W    = 8,
  parameter int B_W    = 8,
  parameter int APPROX = 0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  mul_seq_radix4_if.slave  bus
);
  localparam int N     = B_W / 2;
  localparam int P_W   = A_W + B_W;
  localparam int PP_W  = A_W + 2;
  localparam int CELLS = A_W / 2;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [A_W-1:0]   a_q, a_d;
  logic [B_W-1:0]   b_q, b_d;
  logic [P_W-1:0]   acc_q, acc_d;
  logic [P_W-1:0]   ab_q, ab_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [A_W-1:0]   a_in;
  logic [B_W-1:0]   b_in;
  logic [B_W-1:0]   b_shift;
  logic [1:0]       digit;
  logic [3:0]       cell_p [CELLS];
  logic [PP_W-1:0]  pp;
  logic [P_W-1:0]   acc_sum;
  logic [P_W-1:0]   prod_fin;
  logic             ready, valid, busy;

`ifdef MUL_SEQ_SIGNED_EN
  logic sign_q, sign_d;

  // negation of the most-negative value wraps to 2^(W-1), the correct magnitude
  assign a_in     = bus.i_a[A_W-1] ? -bus.i_a : bus.i_a;
  assign b_in     = bus.i_b[B_W-1] ? -bus.i_b : bus.i_b;
  assign prod_fin = sign_q ? -acc_sum : acc_sum;
`else
  assign a_in     = bus.i_a;
  assign b_in     = bus.i_b;
  assign prod_fin = acc_sum;
`endif

  assign b_shift = b_q >> {cnt_q, 1'b0};
  assign digit   = b_shift[1:0];

  for (genvar k = 0; k < CELLS; k++) begin : g_cell
    mul_2x2 #(
      .APPROX (APPROX)
    ) u_cell (
      .a_i (a_q[2*k +: 2]),
      .b_i (digit),
      .p_o (cell_p[k])
    );
  end

  always_comb begin
    pp = '0;
    for (int k = 0; k < CELLS; k++) begin
      pp = pp + (PP_W'(cell_p[k]) << (2 * k));
    end
    acc_sum = acc_q + (P_W'(pp) << {cnt_q, 1'b0});
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ab_d    = ab_q;
`ifdef MUL_SEQ_SIGNED_EN
    sign_d  = sign_q;
`endif
    ready   = 1'b0;
    valid   = 1'b0;
    busy    = 1'b0;

    case (state_q)
      S_IDLE: begin
        ready = 1'b1;
        if (bus.i_valid) begin
          a_d     = a_in;
          b_d     = b_in;
          acc_d   = '0;
          cnt_d   = '0;
`ifdef MUL_SEQ_SIGNED_EN
          sign_d  = bus.i_a[A_W-1] ^ bus.i_b[B_W-1];
`endif
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        busy  = 1'b1;
        acc_d = acc_sum;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          // product register is separate so it survives the next accept
          ab_d    = prod_fin;
          cnt_d   = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        busy  = 1'b1;
        valid = 1'b1;
        if (bus.i_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      ab_q    <= '0;
`ifdef MUL_SEQ_SIGNED_EN
      sign_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ab_q    <= ab_d;
`ifdef MUL_SEQ_SIGNED_EN
      sign_q  <= sign_d;
`endif
    end
  end

  assign bus.o_ready = ready;
  assign bus.o_valid = valid;
  assign bus.o_busy  = busy;
  assign bus.o_ab    = ab_q;
endmodule
